// File: rtl/hazard_detect.sv
// Load-use and forwarding hazard detector: compares ID sources with the EX/MEM destination slots.
// Optional HAZARD_PERF_EN macro adds stall_cnt/fwd_cnt performance counters.
module hazard_detect #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wen,
    input  logic                  flush,
    output logic                  is_hazard1,
    output logic [2:0]            hazard_reg1,
    output logic                  is_hazard2,
    output logic [2:0]            hazard_reg2,
    output logic                  stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    localparam logic [6:0] LOAD_OP = 7'b0000011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [REG_ADDR_W-1:0] ex_rd_reg;
    logic                  ex_wen_reg;
    logic                  ex_load_reg;
    logic [REG_ADDR_W-1:0] mem_rd_reg;
    logic                  mem_wen_reg;
    logic                  mem_load_reg;

    logic [REG_ADDR_W-1:0] ex_rd_next;
    logic                  ex_wen_next;
    logic                  ex_load_next;

    logic [1:0][REG_ADDR_W-1:0] src_reg;
    logic [1:0]                 src_used;
    logic [1:0]                 ex_m;
    logic [1:0]                 mem_m;
    logic [1:0]                 mem_only;
    logic                       load_use;

    assign src_reg[0]  = id_rs1;
    assign src_reg[1]  = id_rs2;
    assign src_used[0] = id_use_rs1;
    assign src_used[1] = id_use_rs2;

    // Index 0 is rs1, index 1 is rs2; x0 is hardwired and never forwarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                ex_m[gi]     = id_valid && src_used[gi] && ex_wen_reg
                               && (ex_rd_reg == src_reg[gi]) && (src_reg[gi] != '0);
                mem_m[gi]    = id_valid && src_used[gi] && mem_wen_reg
                               && (mem_rd_reg == src_reg[gi]) && (src_reg[gi] != '0);
                mem_only[gi] = mem_m[gi] && !ex_m[gi];
            end
        end
    endgenerate

    assign load_use = (|ex_m) && ex_load_reg;

    always_comb begin
        is_hazard1  = |ex_m;
        hazard_reg1 = 3'd0;
        if (ex_m[0]) begin
            hazard_reg1 = 3'd1;
        end else if (ex_m[1]) begin
            hazard_reg1 = 3'd2;
        end
        is_hazard2  = |mem_only;
        hazard_reg2 = 3'd0;
        if (mem_only[0]) begin
            hazard_reg2 = 3'd3;
        end else if (mem_only[1]) begin
            hazard_reg2 = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // STALL always returns to RUN: the load has reached MEM and is forwarded from there.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (load_use && !flush) state_next = ST_STALL;
            ST_STALL: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (state_reg == ST_RUN) begin
            stall = load_use && !flush;
        end
    end

    always_comb begin
        ex_rd_next   = id_rd;
        ex_wen_next  = id_wen;
        ex_load_next = (id_op == LOAD_OP);
        if (stall || flush || !id_valid) begin
            ex_rd_next   = '0;
            ex_wen_next  = 1'b0;
            ex_load_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_reg    <= '0;
            ex_wen_reg   <= 1'b0;
            ex_load_reg  <= 1'b0;
            mem_rd_reg   <= '0;
            mem_wen_reg  <= 1'b0;
            mem_load_reg <= 1'b0;
        end else begin
            mem_rd_reg   <= ex_rd_reg;
            mem_wen_reg  <= ex_wen_reg;
            mem_load_reg <= ex_load_reg;
            ex_rd_reg    <= ex_rd_next;
            ex_wen_reg   <= ex_wen_next;
            ex_load_reg  <= ex_load_next;
        end
    end

    // The MEM load flag is carried for debug visibility; forwarding only needs rd/wen there.
    logic mem_load_unused;
    assign mem_load_unused = mem_load_reg;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] fwd_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (stall) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (is_hazard1 || is_hazard2) begin
                fwd_cnt_reg <= fwd_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Table-driven bench for hazard_detect: one vector per cycle, expectations queued and checked mid-cycle.
// Counter checks are active when HAZARD_PERF_EN is defined.
module tb_hazard_detect;

    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [6:0] op;
        logic [4:0] rd;
        logic       wen;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       fl;
        logic       h1;
        logic [2:0] r1;
        logic       h2;
        logic [2:0] r2;
        logic       st;
        bit         perf;
        int         sc;
        int         fc;
    } vec_t;

    typedef struct {
        int         idx;
        logic       h1;
        logic [2:0] r1;
        logic       h2;
        logic [2:0] r2;
        logic       st;
        bit         perf;
        int         sc;
        int         fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_wen;
    logic       flush;
    logic       is_hazard1;
    logic [2:0] hazard_reg1;
    logic       is_hazard2;
    logic [2:0] hazard_reg2;
    logic       stall;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_detect #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_wen      (id_wen),
        .flush       (flush),
        .is_hazard1  (is_hazard1),
        .hazard_reg1 (hazard_reg1),
        .is_hazard2  (is_hazard2),
        .hazard_reg2 (hazard_reg2),
        .stall       (stall)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    task automatic v(input logic rst, input logic valid, input logic [6:0] op,
                     input logic [4:0] rd, input logic wen,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic fl,
                     input logic h1, input logic [2:0] r1,
                     input logic h2, input logic [2:0] r2, input logic st);
        vec_t t;
        t.rst = rst; t.valid = valid; t.op = op; t.rd = rd; t.wen = wen;
        t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.fl = fl;
        t.h1 = h1; t.r1 = r1; t.h2 = h2; t.r2 = r2; t.st = st;
        t.perf = 1'b0; t.sc = 0; t.fc = 0;
        vecs.push_back(t);
    endtask

    // ALU instruction rd <- rs1 op rs2 with no expected hazard.
    task automatic alu0(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        v(0, 1, ALU, rd, 1, rs1, 1, rs2, 1, 0, 0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic rstv();
        v(1, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic nopv();
        v(0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic mark_perf(input int sc, input int fc);
        vecs[vecs.size()-1].perf = 1'b1;
        vecs[vecs.size()-1].sc   = sc;
        vecs[vecs.size()-1].fc   = fc;
    endtask

    task automatic run_vec(input vec_t t);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        reset = t.rst; id_valid = t.valid; id_op = t.op; id_rd = t.rd; id_wen = t.wen;
        id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2; flush = t.fl;
        e.idx = vec_no; e.h1 = t.h1; e.r1 = t.r1; e.h2 = t.h2; e.r2 = t.r2; e.st = t.st;
        e.perf = t.perf; e.sc = t.sc; e.fc = t.fc;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        $display("vec %0d rst=%0b v=%0b rd=%0d rs1=%0d rs2=%0d fl=%0b -> h1=%0b r1=%0d h2=%0b r2=%0d stall=%0b",
                 got.idx, t.rst, t.valid, t.rd, t.rs1, t.rs2, t.fl,
                 is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, stall);
        if (is_hazard1 !== got.h1 || hazard_reg1 !== got.r1 || is_hazard2 !== got.h2
            || hazard_reg2 !== got.r2 || stall !== got.st) begin
            failures++;
            $display("FAIL vec%0d outputs: got h1=%0b r1=%0d h2=%0b r2=%0d stall=%0b, want h1=%0b r1=%0d h2=%0b r2=%0d stall=%0b",
                     got.idx, is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, stall,
                     got.h1, got.r1, got.h2, got.r2, got.st);
        end
`ifdef HAZARD_PERF_EN
        if (got.perf) begin
            checks++;
            if (stall_cnt !== got.sc || fwd_cnt !== got.fc) begin
                failures++;
                $display("FAIL vec%0d counters: got stall_cnt=%0d fwd_cnt=%0d, want %0d %0d",
                         got.idx, stall_cnt, fwd_cnt, got.sc, got.fc);
            end
        end
`endif
        vec_no++;
    endtask

    initial begin
        vec_t t;
        reset = 1'b1; id_valid = 1'b0; id_op = ALU; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0; id_wen = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        // EX-distance forward of rs1
        rstv(); alu0(5, 1, 2);
        v(0, 1, ALU, 6, 1, 5, 1, 1, 1, 0, 1, 3'd1, 0, 3'd0, 0);
        // MEM-distance forward of rs2 across a nop
        rstv(); alu0(5, 1, 2); nopv();
        v(0, 1, ALU, 7, 1, 2, 1, 5, 1, 0, 0, 3'd0, 1, 3'd4, 0);
        // load-use: stall one cycle, then forward from MEM
        rstv(); v(0, 1, LD, 5, 1, 1, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0);
        v(0, 1, ALU, 6, 1, 5, 1, 0, 1, 0, 1, 3'd1, 0, 3'd0, 1);
        v(0, 1, ALU, 6, 1, 5, 1, 0, 1, 0, 0, 3'd0, 1, 3'd3, 0);
        alu0(9, 1, 2); mark_perf(1, 2);
        // EX wins, MEM suppressed for covered sources
        rstv(); alu0(5, 1, 2); alu0(5, 3, 4);
        v(0, 1, ALU, 8, 1, 5, 1, 5, 1, 0, 1, 3'd1, 0, 3'd0, 0);
        // x0 never matches
        rstv(); alu0(0, 1, 2); alu0(3, 0, 0); alu0(4, 0, 0);
        // flush beats stall; next instruction sees bubble in EX
        rstv(); v(0, 1, LD, 5, 1, 1, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0);
        v(0, 1, ALU, 6, 1, 5, 1, 1, 1, 1, 1, 3'd1, 0, 3'd0, 0);
        v(0, 1, ALU, 7, 1, 5, 1, 2, 1, 0, 0, 3'd0, 1, 3'd3, 0);
        // rs2 from EX together with rs1 from MEM
        rstv(); alu0(5, 1, 2); alu0(6, 1, 2);
        v(0, 1, ALU, 7, 1, 5, 1, 6, 1, 0, 1, 3'd2, 1, 3'd3, 0);
        // rs2-only EX hit
        rstv(); alu0(5, 1, 2);
        v(0, 1, ALU, 7, 1, 1, 1, 5, 1, 0, 1, 3'd2, 0, 3'd0, 0);
        // load-use through rs2
        rstv(); v(0, 1, LD, 5, 1, 1, 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, 0);
        v(0, 1, ALU, 6, 1, 1, 1, 5, 1, 0, 1, 3'd2, 0, 3'd0, 1);
        v(0, 1, ALU, 6, 1, 1, 1, 5, 1, 0, 0, 3'd0, 1, 3'd4, 0);
        // both sources hit MEM: rs1 code wins
        rstv(); alu0(5, 1, 2); nopv();
        v(0, 1, ALU, 7, 1, 5, 1, 5, 1, 0, 0, 3'd0, 1, 3'd3, 0);
        // invalid ID, unused source, and non-writing producer give no flags
        rstv(); alu0(5, 1, 2);
        v(0, 0, ALU, 7, 1, 5, 1, 5, 1, 0, 0, 3'd0, 0, 3'd0, 0);
        v(0, 1, ALU, 7, 1, 5, 0, 2, 1, 0, 0, 3'd0, 0, 3'd0, 0);
        rstv(); v(0, 1, ALU, 5, 0, 1, 1, 2, 1, 0, 0, 3'd0, 0, 3'd0, 0);
        alu0(6, 5, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Hand-written: reset asserted while the FSM sits in STALL
        t = vecs[0];
        t.rst = 1; t.valid = 0; t.h1 = 0; t.r1 = 0; t.h2 = 0; t.r2 = 0; t.st = 0; t.perf = 0;
        run_vec(t);
        t.rst = 0; t.valid = 1; t.op = LD; t.rd = 5; t.wen = 1; t.rs1 = 1; t.u1 = 1; t.u2 = 0;
        run_vec(t);
        t.op = ALU; t.rd = 6; t.rs1 = 5; t.rs2 = 1; t.u2 = 1; t.h1 = 1; t.r1 = 1; t.st = 1;
        run_vec(t);
        t.rst = 1; t.h1 = 0; t.r1 = 0; t.h2 = 1; t.r2 = 3; t.st = 0;
        run_vec(t);
        t.rst = 0; t.h2 = 0; t.r2 = 0; t.perf = 1; t.sc = 0; t.fc = 0;
        run_vec(t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
